// File: rtl/sevseg_pkg.sv
// Shared seven-segment definitions: active-low {g,f,e,d,c,b,a} patterns for hex 0..F,
// the all-off pattern and the anode-select encodings.
package sevseg_pkg;

   typedef logic [6:0] seg_t;

   localparam seg_t BLANK = 7'b1111111;

   localparam seg_t SEG_TABLE [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // Anodes are active-low, so the single-zero codes select one digit.
   typedef enum logic [1:0] {
      AN_BOTH = 2'b00,
      AN_D1   = 2'b01,
      AN_D0   = 2'b10,
      AN_NONE = 2'b11
   } an_sel_e;

endpackage

// File: rtl/sevseg_inv.sv
// Combinational inverse of the hex segment table: returns the hex value and a hit flag
// when the pattern exactly matches a table entry.
module sevseg_inv
   import sevseg_pkg::*;
(
   input  seg_t        seg,
   output logic [3:0]  hex,
   output logic        hit
);

   always_comb begin
      hex = 4'd0;
      hit = 1'b0;
      for (int i = 0; i < 16; i++) begin
         if (seg == SEG_TABLE[i]) begin
            hex = 4'(i);
            hit = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sevseg_capture.sv
// Captures the hex digits shown on a 2-digit multiplexed seven-segment bus once a pattern
// has been stable for STABLE_CYCLES samples. Optional macro: SEVSEG_CAPTURE_BLANK_EN.
module sevseg_capture
   import sevseg_pkg::*;
#(
   parameter int STABLE_CYCLES = 16
)(
   input  logic        clk,
   input  logic        reset,
   input  logic [6:0]  seg,
   input  logic [1:0]  an,
   output logic [3:0]  digit0,
   output logic [3:0]  digit1,
   output logic [1:0]  valid,
   output logic        update,
   output logic        err
);

   localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

   seg_t       seg_q;
   logic [1:0] an_q;
   logic [7:0] cnt;
   logic       done;
   logic       cap_vld;
   seg_t       cap_seg;
   an_sel_e    cap_an;
   logic [3:0] hex;
   logic       hit;
   logic       differ;
   logic       is_blank;

   assign differ = (seg != seg_q) || (an != an_q);

   sevseg_inv u_inv (
      .seg (cap_seg),
      .hex (hex),
      .hit (hit)
   );

`ifdef SEVSEG_CAPTURE_BLANK_EN
   assign is_blank = (cap_seg == BLANK);
`else
   assign is_blank = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         seg_q   <= BLANK;
         an_q    <= 2'b00;
         cnt     <= 8'd0;
         done    <= 1'b0;
         cap_vld <= 1'b0;
         cap_seg <= BLANK;
         cap_an  <= AN_NONE;
         digit0  <= 4'd0;
         digit1  <= 4'd0;
         valid   <= 2'b00;
         update  <= 1'b0;
         err     <= 1'b0;
      end else begin
         seg_q   <= seg;
         an_q    <= an;
         update  <= 1'b0;
         cap_vld <= 1'b0;

         if (differ) begin
            cnt  <= 8'd0;
            done <= 1'b0;
         end else if (cnt != LAST) begin
            cnt <= cnt + 8'd1;
         end

         // Snapshot the saturated pattern; a simultaneous input change does not cancel it.
         if (cnt == LAST && !done) begin
            cap_vld <= 1'b1;
            cap_seg <= seg_q;
            cap_an  <= an_sel_e'(an_q);
            if (!differ) done <= 1'b1;
         end

         if (cap_vld) begin
            case (cap_an)
               AN_D0: begin
                  update <= 1'b1;
                  if (hit) begin
                     digit0   <= hex;
                     valid[0] <= 1'b1;
                  end else begin
                     valid[0] <= 1'b0;
                     if (!is_blank) err <= 1'b1;
                  end
               end
               AN_D1: begin
                  update <= 1'b1;
                  if (hit) begin
                     digit1   <= hex;
                     valid[1] <= 1'b1;
                  end else begin
                     valid[1] <= 1'b0;
                     if (!is_blank) err <= 1'b1;
                  end
               end
               AN_BOTH: err <= 1'b1;
               default: ;
            endcase
         end
      end
   end

endmodule

// File: doc/sevseg_capture.md
SEVSEG_CAPTURE -- requirements
Module: sevseg_capture

Interface
REQ-001: Parameter STABLE_CYCLES, default 16, is the number of consecutive identical samples required before a capture (legal range 2..255).
REQ-002: clk  input  1  rising-edge clock for all state.
REQ-003: reset  input  1  synchronous, active-low reset.
REQ-004: seg  input  7  multiplexed segment lines {g,f,e,d,c,b,a}, active-low.
REQ-005: an  input  2  digit anode enables, active-low; an[0] selects digit0, an[1] selects digit1.
REQ-006: digit0  output  4  last hex value captured for digit0.
REQ-007: digit1  output  4  last hex value captured for digit1.
REQ-008: valid  output  2  valid[i] high once digit i holds a decoded capture.
REQ-009: update  output  1  one-cycle pulse on each capture.
REQ-010: err  output  1  sticky error flag.

Function
REQ-011: The block SHALL register seg and an in a single input stage (seg_q, an_q) before any comparison.
REQ-012: A saturating stability counter SHALL clear when {seg,an} differs from {seg_q,an_q}, and SHALL otherwise increment.
REQ-013: A capture SHALL occur on the edge at which the counter reaches STABLE_CYCLES-1; the counter then holds (saturates) so each stable pattern is captured exactly once.
REQ-014: update SHALL rise exactly STABLE_CYCLES+1 cycles after the first edge sampling a new {seg,an}, and SHALL remain high for one cycle.
REQ-015: Capture SHALL write only the digit selected by an_q (2'b10 -> digit0, 2'b01 -> digit1) and set its valid bit; the other digit and its valid bit SHALL hold.
REQ-016: an_q == 2'b11 (blanked interval) SHALL produce no capture, no update, and no error.
REQ-017: an_q == 2'b00 (both enabled) SHALL produce no capture and SHALL set err at the capture point.
REQ-018: Decoding SHALL be the exact inverse of the team hex table: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-019: A stable pattern not in the table SHALL set err, SHALL clear the selected valid bit, SHALL leave the digit value unchanged, and SHALL still pulse update.
REQ-020: Once set, err SHALL remain high until reset.
REQ-021: An input change on the same edge as a capture SHALL still let that capture complete, and the counter SHALL restart from 0.

Reset
REQ-022: While reset==0 at a rising edge, digit0, digit1, valid, update, err, the counter, seg_q and an_q SHALL all become 0, except seg_q, which SHALL become 7'b1111111.
REQ-023: A reset asserted mid-count SHALL abandon the pending capture with no update pulse.

Configuration
REQ-024: Macro SEVSEG_CAPTURE_BLANK_EN defined: a stable all-off pattern (7'b1111111) on a selected digit SHALL clear that valid bit, pulse update, and SHALL NOT set err.
REQ-025: Macro SEVSEG_CAPTURE_BLANK_EN undefined: 7'b1111111 SHALL be handled as an undecodable pattern per REQ-019.

Structure
REQ-026: Package sevseg_pkg SHALL hold the seg_t (7-bit) typedef, the 16-entry segment constant table and the BLANK constant, shared with the existing sevseg encoder.
REQ-027: Combinational sub-module sevseg_inv (seg_t in; 4-bit hex and a hit flag out) SHALL perform the table lookup; all sequential logic SHALL reside in sevseg_capture.

Verification
REQ-028: Hold an=10, seg=1000000 for 20 cycles -> a single update at cycle STABLE_CYCLES+1, digit0=0, valid=01, err=0.
REQ-029: Alternate an=10/seg=0001110 and an=01/seg=0000011 every 40 cycles -> digit0=F and digit1=B, one update per dwell, valid=11.
REQ-030: Toggle seg every 8 cycles with STABLE_CYCLES=16 -> no update, digits unchanged.
REQ-031: Hold an=00 with any seg, or seg=0111111 with an=10, for 20 cycles -> err=1; err stays 1 after the inputs become legal, and clears only on reset.
REQ-032: Hold seg=1111111 with an=10 -> with the macro: valid[0]=0, err=0; without it: err=1.
REQ-033: Assert reset at count 10 -> no update; all outputs are 0 on the next edge.
